// File: rtl/mem_access.sv
// mem_access: memory-access stage of the dual-issue pipeline. Drives the
// data-side request/addr_ok/data_ok bus for the bundle's single load/store,
// formats store lanes, aligns and extends load data, flags misalignment and
// reports stage completion on finishM.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        first_cycleM,
  input  logic        flushM,
  input  logic        stallM,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        finishM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_data_req;
  logic        r_data_wr;
  logic [1:0]  r_data_size;
  logic [31:0] r_data_addr;
  logic [3:0]  r_data_wstrb;
  logic [31:0] r_data_wdata;
  logic        r_sext;
  logic [31:0] r_rdata;
  logic        r_adel;
  logic        r_ades;
  logic        r_pend;

  // Bundle fields captured at first_cycleM, used when a launch is deferred
  logic [31:0] r_b_addr;
  logic [31:0] r_b_wdata;
  logic [1:0]  r_b_size;
  logic        r_b_wr;
  logic        r_b_sext;

  logic        w_misal;
  logic        w_launch;
  logic        w_enter_req;
  logic        w_load_done;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [1:0]  w_sel_size;
  logic        w_sel_wr;
  logic        w_sel_sext;

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    f_misaligned = 1'b0;
      2'd1:    f_misaligned = a[0];
      default: f_misaligned = (a != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(input logic wr, input logic [1:0] size, input logic [1:0] a);
    if (!wr) f_wstrb = 4'b0000;
    else begin
      case (size)
        2'd0:    f_wstrb = 4'b0001 << a;
        2'd1:    f_wstrb = 4'b0011 << a;
        default: f_wstrb = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    f_wdata = {4{d[7:0]}};
      2'd1:    f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] f_addr(input logic [1:0] size, input logic [31:0] a);
    f_addr = size[1] ? {a[31:2], 2'b00} : a;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic sext,
                                         input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    f_load = {{24{sext & b[7]}}, b};
      2'd1:    f_load = {{16{sext & h[15]}}, h};
      default: f_load = rd;
    endcase
  endfunction

  assign w_misal  = mem_en & f_misaligned(mem_size, addr[1:0]);
  assign w_launch = first_cycleM & mem_en & ~w_misal & ~flushM;

  // Live inputs while the bundle pulse is present, captured copy afterwards
  assign w_sel_addr  = first_cycleM ? addr     : r_b_addr;
  assign w_sel_wdata = first_cycleM ? wdata    : r_b_wdata;
  assign w_sel_size  = first_cycleM ? mem_size : r_b_size;
  assign w_sel_wr    = first_cycleM ? mem_wr   : r_b_wr;
  assign w_sel_sext  = first_cycleM ? mem_sext : r_b_sext;

  assign w_enter_req = (w_state_nxt == S_REQ) && (r_state != S_REQ);
  assign w_load_done = ~r_data_wr & ~flushM &
                       (((r_state == S_REQ) & data_addr_ok & data_data_ok) |
                        ((r_state == S_WAIT) & data_data_ok));

  assign adel       = first_cycleM ? (w_misal & ~mem_wr) : r_adel;
  assign ades       = first_cycleM ? (w_misal &  mem_wr) : r_ades;
  assign rdata      = r_rdata;
  assign data_req   = r_data_req;
  assign data_wr    = r_data_wr;
  assign data_size  = r_data_size;
  assign data_addr  = r_data_addr;
  assign data_wstrb = r_data_wstrb;
  assign data_wdata = r_data_wdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and completion decode
  always_comb begin
    w_state_nxt = r_state;
    finishM     = 1'b0;
    case (r_state)
      S_IDLE: begin
        finishM = ~w_launch;
        if (w_launch) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) w_state_nxt = flushM ? S_IDLE : S_DONE;
          else              w_state_nxt = flushM ? S_CANCEL : S_WAIT;
        end else if (flushM) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) w_state_nxt = flushM ? S_IDLE : S_DONE;
        else if (flushM)  w_state_nxt = S_CANCEL;
      end
      S_DONE: begin
        if (first_cycleM) begin
          finishM     = ~w_launch;
          w_state_nxt = w_launch ? S_REQ : S_IDLE;
        end else begin
          finishM = 1'b1;
          if (flushM && !stallM) w_state_nxt = S_IDLE;
        end
      end
      S_CANCEL: begin
        if (data_data_ok)
          w_state_nxt = ((r_pend & ~flushM) | w_launch) ? S_REQ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus request registers, load result and exception flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= 2'd0;
      r_data_addr  <= 32'd0;
      r_data_wstrb <= 4'd0;
      r_data_wdata <= 32'd0;
      r_sext       <= 1'b0;
      r_rdata      <= 32'd0;
      r_adel       <= 1'b0;
      r_ades       <= 1'b0;
    end else begin
      r_data_req <= (w_state_nxt == S_REQ);
      if (w_enter_req) begin
        r_data_wr    <= w_sel_wr;
        r_data_size  <= w_sel_size;
        r_data_addr  <= f_addr(w_sel_size, w_sel_addr);
        r_data_wstrb <= f_wstrb(w_sel_wr, w_sel_size, w_sel_addr[1:0]);
        r_data_wdata <= f_wdata(w_sel_size, w_sel_wdata);
        r_sext       <= w_sel_sext;
      end
      if (w_load_done)
        r_rdata <= f_load(r_data_size, r_sext, r_data_addr[1:0], data_rdata);
      if (first_cycleM) begin
        r_adel <= w_misal & ~mem_wr;
        r_ades <= w_misal &  mem_wr;
      end
    end
  end

  // Records a bundle that arrives while a cancelled access is still draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pend <= 1'b0;
    else if (r_state == S_CANCEL) begin
      if (data_data_ok)  r_pend <= 1'b0;
      else if (flushM)   r_pend <= 1'b0;
      else if (w_launch) r_pend <= 1'b1;
    end else begin
      r_pend <= 1'b0;
    end
  end

  // Bundle capture for deferred launch
  always_ff @(posedge clk) begin
    if (first_cycleM) begin
      r_b_addr  <= addr;
      r_b_wdata <= wdata;
      r_b_size  <= mem_size;
      r_b_wr    <= mem_wr;
      r_b_sext  <= mem_sext;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scenarios for mem_access with a load-result scoreboard.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        first_cycleM, flushM, stallM, mem_en, mem_wr, mem_sext;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        adel, ades, finishM, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_exp[$];
  logic [31:0] exp_v;

  mem_access dut (
    .clk(clk), .reset(reset), .first_cycleM(first_cycleM), .flushM(flushM),
    .stallM(stallM), .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sext(mem_sext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .adel(adel), .ades(ades), .finishM(finishM), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven for that cycle
  task automatic tick();
    @(posedge clk);
    #1;
    first_cycleM = 1'b0; flushM = 1'b0; stallM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic bundle(input logic en, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd);
    first_cycleM = 1'b1; mem_en = en; mem_wr = wr; mem_size = sz;
    mem_sext = sx; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    first_cycleM = 0; flushM = 0; stallM = 0; mem_en = 0; mem_wr = 0;
    mem_size = 0; mem_sext = 0; addr = 0; wdata = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_vec++; if ({adel, ades} !== 2'b00) begin n_err++; $display("FAIL reset_exc got %b want 00", {adel, ades}); end
    n_vec++; if ({data_req, data_wr, data_wstrb} !== 6'b0) begin n_err++; $display("FAIL reset_bus got %b want 0", {data_req, data_wr, data_wstrb}); end
    n_vec++; if ({data_addr, data_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_addr_data got %h want 0", {data_addr, data_wdata}); end
    n_vec++; if (finishM !== 1'b1) begin n_err++; $display("FAIL reset_finish got %b want 1", finishM); end
  endtask

  task automatic test_lw_wait();
    tick(); bundle(1, 0, 2'd2, 0, 32'h8000_1004, 32'h0); q_exp.push_back(32'hDEAD_BEEF); #1;
    n_vec++; if (finishM !== 1'b0) begin n_err++; $display("FAIL lw_t0_finish got %b want 0", finishM); end
    tick(); data_addr_ok = 1'b1; #1;
    n_vec++; if (data_req !== 1'b1) begin n_err++; $display("FAIL lw_t1_req got %b want 1", data_req); end
    n_vec++; if (data_addr !== 32'h8000_1004) begin n_err++; $display("FAIL lw_t1_addr got %h want 80001004", data_addr); end
    n_vec++; if ({data_wr, data_wstrb, data_size} !== 7'b0_0000_10) begin n_err++; $display("FAIL lw_t1_ctl got %b want 0000010", {data_wr, data_wstrb, data_size}); end
    tick(); #1;
    n_vec++; if ({data_req, finishM} !== 2'b00) begin n_err++; $display("FAIL lw_t2_req_fin got %b want 00", {data_req, finishM}); end
    tick(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #1;
    n_vec++; if (finishM !== 1'b0) begin n_err++; $display("FAIL lw_t3_finish got %b want 0", finishM); end
    tick(); data_rdata = 32'h5555_5555; #1;
    n_vec++; if (finishM !== 1'b1) begin n_err++; $display("FAIL lw_t4_finish got %b want 1", finishM); end
    n_vec++;
    if (q_exp.size() == 0) begin n_err++; $display("FAIL lw_sb empty queue, rdata %h", rdata); end
    else begin exp_v = q_exp.pop_front(); if (rdata !== exp_v) begin n_err++; $display("FAIL lw_rdata got %h want %h", rdata, exp_v); end end
  endtask

  task automatic test_lb(input logic sx, input logic [31:0] want);
    tick(); bundle(1, 0, 2'd0, sx, 32'h8000_1003, 32'h0); q_exp.push_back(want);
    tick(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF_7F01; #1;
    n_vec++; if ({data_req, data_size} !== 3'b1_00) begin n_err++; $display("FAIL lb_req_size got %b want 100", {data_req, data_size}); end
    n_vec++; if (data_addr !== 32'h8000_1003) begin n_err++; $display("FAIL lb_addr got %h want 80001003", data_addr); end
    tick(); data_rdata = 32'h0; #1;
    n_vec++; if ({finishM, data_req} !== 2'b10) begin n_err++; $display("FAIL lb_done got %b want 10", {finishM, data_req}); end
    n_vec++;
    if (q_exp.size() == 0) begin n_err++; $display("FAIL lb_sb empty queue, rdata %h", rdata); end
    else begin exp_v = q_exp.pop_front(); if (rdata !== exp_v) begin n_err++; $display("FAIL lb_rdata sext=%0b got %h want %h", sx, rdata, exp_v); end end
  endtask

  task automatic test_sh();
    tick(); bundle(1, 1, 2'd1, 0, 32'h8000_1002, 32'h1234_ABCD);
    tick(); data_addr_ok = 1'b1; #1;
    n_vec++; if ({data_req, data_wr, data_wstrb} !== 6'b11_1100) begin n_err++; $display("FAIL sh_ctl got %b want 111100", {data_req, data_wr, data_wstrb}); end
    n_vec++; if (data_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got %h want abcdabcd", data_wdata); end
    tick(); data_data_ok = 1'b1; #1;
    n_vec++; if (finishM !== 1'b0) begin n_err++; $display("FAIL sh_wait_finish got %b want 0", finishM); end
    tick(); #1;
    n_vec++; if (finishM !== 1'b1) begin n_err++; $display("FAIL sh_finish got %b want 1", finishM); end
    n_vec++; if (rdata !== 32'h0000_0080) begin n_err++; $display("FAIL sh_rdata_kept got %h want 00000080", rdata); end
  endtask

  task automatic test_misaligned();
    tick(); bundle(1, 0, 2'd2, 0, 32'h8000_1002, 32'h0); #1;
    n_vec++; if ({adel, ades, finishM} !== 3'b101) begin n_err++; $display("FAIL mis_lw_t0 got %b want 101", {adel, ades, finishM}); end
    tick(); addr = 32'h8000_1000; #1;
    n_vec++; if ({adel, data_req, finishM} !== 3'b101) begin n_err++; $display("FAIL mis_lw_t1 got %b want 101", {adel, data_req, finishM}); end
    tick(); bundle(1, 1, 2'd1, 0, 32'h8000_1001, 32'h0); #1;
    n_vec++; if ({adel, ades, finishM} !== 3'b011) begin n_err++; $display("FAIL mis_sh_t0 got %b want 011", {adel, ades, finishM}); end
    tick(); #1;
    n_vec++; if ({ades, data_req} !== 2'b10) begin n_err++; $display("FAIL mis_sh_t1 got %b want 10", {ades, data_req}); end
  endtask

  task automatic test_no_mem();
    tick(); bundle(0, 0, 2'd2, 0, 32'h8000_1002, 32'h0); #1;
    n_vec++; if ({adel, ades, finishM} !== 3'b001) begin n_err++; $display("FAIL nomem_t0 got %b want 001", {adel, ades, finishM}); end
    tick(); #1;
    n_vec++; if ({data_req, finishM} !== 2'b01) begin n_err++; $display("FAIL nomem_t1 got %b want 01", {data_req, finishM}); end
  endtask

  task automatic test_flush_req();
    tick(); bundle(1, 0, 2'd2, 0, 32'h8000_3000, 32'h0);
    tick(); flushM = 1'b1; #1;
    n_vec++; if ({data_req, finishM} !== 2'b10) begin n_err++; $display("FAIL flreq_t1 got %b want 10", {data_req, finishM}); end
    tick(); #1;
    n_vec++; if ({data_req, finishM} !== 2'b01) begin n_err++; $display("FAIL flreq_t2 got %b want 01", {data_req, finishM}); end
  endtask

  task automatic test_back_to_back();
    tick(); bundle(1, 0, 2'd2, 0, 32'h8000_2000, 32'h0);
    tick(); data_addr_ok = 1'b1; #1;
    n_vec++; if (data_req !== 1'b1) begin n_err++; $display("FAIL cancel_t1_req got %b want 1", data_req); end
    tick(); flushM = 1'b1; #1;
    n_vec++; if (finishM !== 1'b0) begin n_err++; $display("FAIL cancel_t2_finish got %b want 0", finishM); end
    tick(); bundle(1, 0, 2'd2, 0, 32'h8000_2004, 32'h0); q_exp.push_back(32'h0BAD_F00D); #1;
    n_vec++; if ({data_req, finishM} !== 2'b00) begin n_err++; $display("FAIL cancel_t3 got %b want 00", {data_req, finishM}); end
    tick(); addr = 32'h0; #1;
    n_vec++; if (data_req !== 1'b0) begin n_err++; $display("FAIL cancel_t4_req got %b want 0", data_req); end
    tick(); data_data_ok = 1'b1; data_rdata = 32'h1111_1111; #1;
    n_vec++; if (data_req !== 1'b0) begin n_err++; $display("FAIL cancel_t5_req got %b want 0", data_req); end
    tick(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; #1;
    n_vec++; if ({data_req, data_addr} !== {1'b1, 32'h8000_2004}) begin n_err++; $display("FAIL cancel_t6_req got %b/%h want 1/80002004", data_req, data_addr); end
    n_vec++; if (rdata !== 32'h0000_0080) begin n_err++; $display("FAIL cancel_t6_rdata got %h want 00000080", rdata); end
    tick(); #1;
    n_vec++; if (finishM !== 1'b1) begin n_err++; $display("FAIL cancel_t7_finish got %b want 1", finishM); end
    n_vec++;
    if (q_exp.size() == 0) begin n_err++; $display("FAIL cancel_sb empty queue, rdata %h", rdata); end
    else begin exp_v = q_exp.pop_front(); if (rdata !== exp_v) begin n_err++; $display("FAIL cancel_rdata got %h want %h", rdata, exp_v); end end
  endtask

  task automatic test_reset_mid();
    tick(); bundle(1, 1, 2'd2, 0, 32'h8000_4000, 32'hCAFE_F00D);
    tick(); #1;
    n_vec++; if ({data_req, data_wr} !== 2'b11) begin n_err++; $display("FAIL rstmid_req got %b want 11", {data_req, data_wr}); end
    reset = 1'b1; #1;
    n_vec++; if ({data_req, data_wr, finishM} !== 3'b001) begin n_err++; $display("FAIL rstmid_bus got %b want 001", {data_req, data_wr, finishM}); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
    tick(); reset = 1'b0; #1;
    n_vec++; if ({data_req, finishM} !== 2'b01) begin n_err++; $display("FAIL rstmid_after got %b want 01", {data_req, finishM}); end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_lb(1'b1, 32'hFFFF_FF80);
    test_lb(1'b0, 32'h0000_0080);
    test_sh();
    test_misaligned();
    test_no_mem();
    test_flush_req();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (q_exp.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d entries want 0", q_exp.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage for the dual-issue in-order pipeline, directly downstream of the execute stage. It takes the single load/store of the current two-lane bundle, already selected by the issue rules, and drives the data-side SRAM-like bus with a request/address-ok/data-ok handshake. It formats store byte-lanes and extends load data, flags misaligned addresses, and reports completion through `finishM` so the pipeline control can release the bundle.

## Interface
Parameters
- none; address/data width fixed at 32 bits

Ports
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `first_cycleM`  in  1  one-cycle pulse when a new bundle enters this stage
- `flushM`  in  1  discard current bundle
- `stallM`  in  1  pipeline holds this stage; hold result/state
- `mem_en`  in  1  bundle contains a memory op
- `mem_wr`  in  1  1 = store, 0 = load
- `mem_size`  in  2  0 = byte, 1 = half, 2 = word
- `mem_sext`  in  1  sign-extend load (LB/LH)
- `addr`  in  32  effective address from execute
- `wdata`  in  32  store data (low bits significant)
- `rdata`  out  32  aligned, extended load result
- `adel` / `ades`  out  1 / 1  load / store address error
- `finishM`  out  1  stage complete for current bundle
- `data_req`, `data_wr`  out  1 / 1  bus request, write
- `data_size`  out  2  copy of `mem_size`
- `data_addr`  out  32  `{addr[31:2],2'b00}` for word; `addr` otherwise
- `data_wstrb`  out  4  byte enables
- `data_wdata`  out  32  replicated store data
- `data_addr_ok`, `data_data_ok`  in  1 / 1  handshake
- `data_rdata`  in  32  read word

## Operation
- Misalignment: half requires `addr[0]==0`; word requires `addr[1:0]==0`. A violation raises `adel` (load) or `ades` (store), issues no bus request, and sets `finishM=1` immediately.
- Store formatting:
  - byte: `wstrb = 4'b0001<<addr[1:0]`, `wdata = {4{wdata[7:0]}}`
  - half: `wstrb = 4'b0011<<addr[1:0]`, `wdata = {2{wdata[15:0]}}`
  - word: `wstrb = 4'b1111`
  - loads: `wstrb = 0`
- Load formatting: select the byte or half at `addr[1:0]` from `data_rdata`; zero- or sign-extend per `mem_sext`; word loads pass through.
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
  - IDLE: on `first_cycleM & mem_en & aligned & !flushM` go to REQ. Otherwise `finishM=1` (no memop, or exception).
  - REQ: `data_req=1`, all bus outputs stable. On `data_addr_ok` go to WAIT; if `data_data_ok` is also high in the same cycle, go straight to DONE. `flushM` in REQ without `addr_ok` goes to IDLE and drops the request.
  - WAIT: on `data_data_ok`, latch formatted `rdata` and go to DONE. On `flushM` go to CANCEL.
  - DONE: `finishM=1`, `rdata` held. Leave to IDLE on the next `first_cycleM`, or on `flushM` with `!stallM`.
  - CANCEL: wait for `data_data_ok`, discard the data, go to IDLE. `finishM=0` throughout.
- `stallM` freezes DONE and the latched result. It does not block the REQ/WAIT handshake.
- A `first_cycleM` pulse arriving in CANCEL is recorded, and the request launches after the drain completes.

## Timing
- Reset values: state=IDLE, `rdata=0`, `adel=ades=0`, `data_req=0`, `data_wr=0`, `data_wstrb=0`, `data_addr=0`, `data_wdata=0`. `finishM=1` (IDLE with no memop).
- Bus outputs are registered, so `data_req` rises the cycle after `first_cycleM`.
- Minimum load/store latency: `first_cycleM` at T0; `data_req` at T1; `addr_ok` and `data_ok` at T1; DONE and `finishM` at T2.
- `adel`/`ades` are combinational from the inputs while `first_cycleM` is high, then held until the next bundle.
- Only one outstanding transaction at a time. A new REQ never overlaps WAIT or CANCEL.
- Reset asserted mid-transaction returns to IDLE immediately. Any bus response still in flight is the bus side's responsibility.

## Test plan
- LW at `0x80001004`, `addr_ok` T1, `data_ok` T3 with `0xDEADBEEF` -> `rdata=0xDEADBEEF`; `finishM` first high at T4.
- LB, sext, at `0x80001003`, `data_rdata=0x80FF7F01` -> `rdata=0xFFFFFF80`. The same with LBU -> `0x00000080`.
- SH at `0x80001002`, `wdata=0x1234ABCD` -> `data_wstrb=4'b1100`, `data_wdata=0xABCDABCD`, `data_wr=1`; `finishM` after `data_ok`.
- LW at `0x80001002` -> `adel=1`, `data_req` never asserted, `finishM=1` in the same cycle.
- LW: `addr_ok` at T1, `flushM` at T2, `data_ok` at T5; the next LW bundle's `first_cycleM` arrives at T3 -> the second request is not issued until T6, and the first load's data is not reflected in `rdata`.
- Bundle with `mem_en=0` -> `finishM=1`, no bus activity.
